// File: rtl/pulse_pkg.sv
// Shared types for the pulse dispatch path: descriptor payload, widths and dispatch FSM states.
package pulse_pkg;

  localparam int unsigned WID_W      = 8;
  localparam int unsigned TS_W_DEF   = 32;
  localparam int unsigned DUR_W_DEF  = 16;
  localparam int unsigned CH_FIELD_W = 4;

  typedef struct packed {
    logic [CH_FIELD_W-1:0] ch;
    logic [TS_W_DEF-1:0]   start_time;
    logic [DUR_W_DEF-1:0]  duration;
    logic [WID_W-1:0]      wave_id;
  } pulse_descriptor_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_TIME,
    ST_WAIT_CH,
    ST_ISSUE
  } dispatch_state_e;

endpackage

// File: rtl/pulse_ch_timer.sv
// Per-channel duration down-counter; active is high for max(duration,1) cycles after load.
module pulse_ch_timer #(
  parameter int unsigned DUR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DUR_W-1:0] duration,
  output logic             active
);

  logic [DUR_W-1:0] cnt_q;
  logic [DUR_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (duration == '0) ? DUR_W'(1) : duration;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DUR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      active <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      active <= (cnt_d != '0);
    end
  end

endmodule

// File: rtl/pulse_dispatch_ctrl.sv
// Timebase owner and descriptor dispatcher between the pulse FIFO and channel engines.
// Optional build macro PULSE_DISPATCH_DROP_LATE_EN drops late pulses and adds late_drop_cnt.
module pulse_dispatch_ctrl
  import pulse_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned TS_W   = TS_W_DEF,
  parameter int unsigned DUR_W  = DUR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tb_run,
  input  logic              tb_clear,
  input  pulse_descriptor_t fifo_rd_data,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [NUM_CH-1:0] play_start,
  output logic [WID_W-1:0]  play_wave_id,
  output logic [DUR_W-1:0]  play_duration,
  output logic [NUM_CH-1:0] ch_active,
  output logic [TS_W-1:0]   timebase,
  output logic              late_err,
  output logic              collision_err,
  input  logic              err_clear
`ifdef PULSE_DISPATCH_DROP_LATE_EN
  ,
  output logic [15:0]       late_drop_cnt
`endif
);

  localparam int unsigned CH_IDX_W = $clog2(NUM_CH);

  dispatch_state_e      state_q;
  dispatch_state_e      state_d;
  logic                 issue;
  logic                 coll_set;
  logic                 late_set;
  logic                 play_go;
  logic [TS_W-1:0]      head_start;
  logic [TS_W-1:0]      tb_diff;
  logic                 reached;
  logic                 on_time;
  logic                 head_ch_ok;
  logic [CH_IDX_W-1:0]  head_idx;
  logic                 head_busy;

  // Wrap-safe "reached": sign bit of the modular distance timebase - start_time
  assign head_start = TS_W'(fifo_rd_data.start_time);
  assign tb_diff    = timebase - head_start;
  assign reached    = ~tb_diff[TS_W-1];
  assign on_time    = (timebase == head_start);
  assign head_ch_ok = (32'(fifo_rd_data.ch) < NUM_CH);
  assign head_idx   = CH_IDX_W'(fifo_rd_data.ch);
  assign head_busy  = head_ch_ok & ch_active[head_idx];
  assign late_set   = issue & ~on_time;

`ifdef PULSE_DISPATCH_DROP_LATE_EN
  assign play_go = issue & head_ch_ok & on_time;
`else
  assign play_go = issue & head_ch_ok;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    coll_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_WAIT_TIME;
      end
      ST_WAIT_TIME: begin
        if (fifo_empty) begin
          state_d = ST_IDLE;
        end else if (reached) begin
          if (!head_ch_ok) begin
            issue    = 1'b1;
            coll_set = 1'b1;
          end else if (head_busy) begin
            state_d  = ST_WAIT_CH;
            coll_set = 1'b1;
          end else begin
            issue = 1'b1;
          end
        end
      end
      ST_WAIT_CH: begin
        if (fifo_empty) begin
          state_d = ST_IDLE;
        end else if (!head_busy) begin
          issue = 1'b1;
        end
      end
      // An empty FIFO after the pop is caught by WAIT_TIME and routed to IDLE
      ST_ISSUE: state_d = ST_WAIT_TIME;
      default:  state_d = ST_IDLE;
    endcase
    if (issue) state_d = ST_ISSUE;
  end

  // Issue outputs are registered so they line up with the ISSUE state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_rd_en    <= 1'b0;
      play_start    <= '0;
      play_wave_id  <= '0;
      play_duration <= '0;
      late_err      <= 1'b0;
      collision_err <= 1'b0;
    end else begin
      fifo_rd_en    <= issue;
      play_start    <= play_go ? (NUM_CH'(1) << head_idx) : '0;
      play_wave_id  <= play_go ? fifo_rd_data.wave_id : '0;
      play_duration <= play_go ? DUR_W'(fifo_rd_data.duration) : '0;
      late_err      <= late_set | (late_err & ~err_clear);
      collision_err <= coll_set | (collision_err & ~err_clear);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timebase <= '0;
    end else if (tb_clear) begin
      timebase <= '0;
    end else if (tb_run) begin
      timebase <= timebase + TS_W'(1);
    end
  end

`ifdef PULSE_DISPATCH_DROP_LATE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      late_drop_cnt <= '0;
    end else if (issue && head_ch_ok && !on_time && (late_drop_cnt != 16'hFFFF)) begin
      late_drop_cnt <= late_drop_cnt + 16'd1;
    end
  end
`endif

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_timer
    pulse_ch_timer #(.DUR_W(DUR_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (play_start[g]),
      .duration (play_duration),
      .active   (ch_active[g])
    );
  end

endmodule
